bp_resolve_sink: RTL and testbench

- Frontend-side receiver of the branch unit's resolved-branch stream.
- Turns each mispredict into a held, PCC-carrying redirect request toward PC generation.
- Queues BHT/BTB training updates in a small FIFO and drains them over a valid/ready port to the predictor tables.
- Sits in the frontend, between the execute-stage branch resolution and PC gen / BHT / BTB.

---
 rtl/cva6_bp_pkg.sv | 27 ++
 rtl/bp_upd_fifo.sv | 70 +++++++
 rtl/bp_resolve_sink.sv | 160 ++++++++++++++++
 tb/tb_bp_resolve_sink.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_bp_pkg.sv
// Shared types for the branch-resolution sink: control-flow kinds,
// predictor update entries and the redirect FSM states.
package cva6_bp_pkg;

    localparam int unsigned BP_VLEN = 64;

    typedef enum logic [2:0] {
        CF_NONE   = 3'd0,
        CF_BRANCH = 3'd1,
        CF_JUMP   = 3'd2,
        CF_JUMPR  = 3'd3,
        CF_RETURN = 3'd4
    } cf_t;

    typedef struct packed {
        logic               is_btb;
        logic [BP_VLEN-1:0] pc;
        logic [BP_VLEN-1:0] target;
        logic               taken;
    } bp_upd_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } bp_redir_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Drop-oldest FIFO for predictor training updates; a push into a full FIFO
// without a concurrent pop evicts the head and flags drop_o.
module bp_upd_fifo
    import cva6_bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  bp_upd_entry_t data_i,
    input  logic          pop_i,
    output bp_upd_entry_t head_o,
    output logic          empty_o,
    output logic          drop_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    bp_upd_entry_t mem_q [DEPTH];
    bp_upd_entry_t mem_d [DEPTH];
    logic          full;
    logic          pop_eff;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_o   = 1'b0;
        pop_eff  = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_i) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                // Full with no pop: the write lands on the head slot, so advance past it.
                if (full && !pop_eff) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    drop_o   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_resolve_sink.sv
// Frontend sink for resolved branches: held redirect on mispredict plus a
// queued BHT/BTB update stream. Optional counters: BP_RESOLVE_PERF_CNT_EN.
module bp_resolve_sink
    import cva6_bp_pkg::*;
#(
    parameter int unsigned VLEN         = 64,
    parameter int unsigned PCLEN        = 128,
    parameter int unsigned DEPTH        = 4,
    parameter bit          CheriPresent = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             res_valid_i,
    input  logic [VLEN-1:0]  res_pc_i,
    input  logic [PCLEN-1:0] res_target_i,
    input  logic             res_is_taken_i,
    input  logic             res_is_mispredict_i,
    input  logic [2:0]       res_cf_type_i,
    input  logic             flush_i,
    output logic             redirect_valid_o,
    output logic [PCLEN-1:0] redirect_pcc_o,
    input  logic             redirect_ready_i,
    output logic             upd_valid_o,
    output logic             upd_is_btb_o,
    output logic [VLEN-1:0]  upd_pc_o,
    output logic [VLEN-1:0]  upd_target_o,
    output logic             upd_taken_o,
    input  logic             upd_ready_i,
    output logic             upd_drop_o
`ifdef BP_RESOLVE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_resolved_o,
    output logic [31:0]      perf_mispredict_o,
    output logic [31:0]      perf_drop_o
`endif
);

    bp_redir_state_t  state_q, state_d;
    logic [PCLEN-1:0] target_q, target_d;
    logic             mispredict;
    logic             upd_push;
    bp_upd_entry_t    upd_entry;
    bp_upd_entry_t    upd_head;
    logic             upd_empty;

    assign mispredict = res_valid_i && res_is_mispredict_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mispredict) begin
                        state_d  = ST_REDIRECT;
                        target_d = res_target_i;
                    end
                end
                ST_REDIRECT: begin
                    // A mispredict only replaces the target once the old one is accepted.
                    if (redirect_ready_i) begin
                        if (mispredict) target_d = res_target_i;
                        else            state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        redirect_valid_o = (state_q == ST_REDIRECT);
        redirect_pcc_o   = '0;
        if (redirect_valid_o) begin
            if (CheriPresent) redirect_pcc_o = target_q;
            else              redirect_pcc_o = {{(PCLEN-VLEN){1'b0}}, target_q[VLEN-1:0]};
        end
    end

    always_comb begin
        upd_entry        = '0;
        upd_entry.pc     = BP_VLEN'(res_pc_i);
        upd_push         = 1'b0;
        if (res_cf_type_i == CF_BRANCH) begin
            upd_push        = 1'b1;
            upd_entry.taken = res_is_taken_i;
        end else if (res_cf_type_i == CF_JUMPR && res_is_mispredict_i) begin
            upd_push         = 1'b1;
            upd_entry.is_btb = 1'b1;
            upd_entry.target = BP_VLEN'(res_target_i[VLEN-1:0]);
        end
        upd_push = upd_push && res_valid_i && !flush_i && !rst_i;
    end

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_upd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (upd_push),
        .data_i  (upd_entry),
        .pop_i   (upd_ready_i),
        .head_o  (upd_head),
        .empty_o (upd_empty),
        .drop_o  (upd_drop_o)
    );

    always_comb begin
        upd_valid_o  = !upd_empty;
        upd_is_btb_o = upd_valid_o && upd_head.is_btb;
        upd_taken_o  = upd_valid_o && upd_head.taken;
        upd_pc_o     = upd_valid_o ? upd_head.pc[VLEN-1:0] : '0;
        upd_target_o = upd_valid_o ? upd_head.target[VLEN-1:0] : '0;
    end

`ifdef BP_RESOLVE_PERF_CNT_EN
    logic [31:0] perf_res_q, perf_res_d;
    logic [31:0] perf_mis_q, perf_mis_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    always_comb begin
        perf_res_d  = perf_res_q;
        perf_mis_d  = perf_mis_q;
        perf_drop_d = perf_drop_q;
        if (res_valid_i && perf_res_q != '1) perf_res_d  = perf_res_q + 32'd1;
        if (mispredict && perf_mis_q != '1)  perf_mis_d  = perf_mis_q + 32'd1;
        if (upd_drop_o && perf_drop_q != '1) perf_drop_d = perf_drop_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_res_q  <= '0;
            perf_mis_q  <= '0;
            perf_drop_q <= '0;
        end else begin
            perf_res_q  <= perf_res_d;
            perf_mis_q  <= perf_mis_d;
            perf_drop_q <= perf_drop_d;
        end
    end

    assign perf_resolved_o   = perf_res_q;
    assign perf_mispredict_o = perf_mis_q;
    assign perf_drop_o       = perf_drop_q;
`endif

endmodule

// File: tb/tb_bp_resolve_sink.sv
// Bench for bp_resolve_sink: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model.
module tb_bp_resolve_sink;

    localparam int unsigned VLEN  = 64;
    localparam int unsigned PCLEN = 128;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, res_valid, res_taken, res_mis, flush, redirect_ready, upd_ready;
    logic [VLEN-1:0]  res_pc;
    logic [PCLEN-1:0] res_target;
    logic [2:0]       res_cf;
    logic             redirect_valid_o, upd_valid_o, upd_is_btb_o, upd_taken_o, upd_drop_o;
    logic [PCLEN-1:0] redirect_pcc_o;
    logic [VLEN-1:0]  upd_pc_o, upd_target_o;
`ifdef BP_RESOLVE_PERF_CNT_EN
    logic [31:0]      perf_resolved_o, perf_mispredict_o, perf_drop_o;
`endif

    bp_resolve_sink #(
        .VLEN         (VLEN),
        .PCLEN        (PCLEN),
        .DEPTH        (DEPTH),
        .CheriPresent (1'b1)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .res_valid_i         (res_valid),
        .res_pc_i            (res_pc),
        .res_target_i        (res_target),
        .res_is_taken_i      (res_taken),
        .res_is_mispredict_i (res_mis),
        .res_cf_type_i       (res_cf),
        .flush_i             (flush),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pcc_o      (redirect_pcc_o),
        .redirect_ready_i    (redirect_ready),
        .upd_valid_o         (upd_valid_o),
        .upd_is_btb_o        (upd_is_btb_o),
        .upd_pc_o            (upd_pc_o),
        .upd_target_o        (upd_target_o),
        .upd_taken_o         (upd_taken_o),
        .upd_ready_i         (upd_ready),
        .upd_drop_o          (upd_drop_o)
`ifdef BP_RESOLVE_PERF_CNT_EN
        ,
        .perf_resolved_o     (perf_resolved_o),
        .perf_mispredict_o   (perf_mispredict_o),
        .perf_drop_o         (perf_drop_o)
`endif
    );

    typedef struct {
        logic            is_btb;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] tgt;
        logic            taken;
    } exp_upd_t;

    exp_upd_t         q[$];
    bit               m_pend = 1'b0;
    logic [PCLEN-1:0] m_tgt  = '0;
    int unsigned      m_perf_res = 0, m_perf_mis = 0, m_perf_drop = 0;
    int               n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [PCLEN-1:0] obs, input logic [PCLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_push();
        return res_valid && !flush && !rst &&
               (res_cf == 3'd1 || (res_cf == 3'd3 && res_mis));
    endfunction

    // Check outputs mid-cycle, then advance the model at the clock edge.
    task automatic cyc();
        bit       push, pop, exp_drop;
        exp_upd_t e;
        @(negedge clk);
        push     = m_push();
        pop      = (q.size() > 0) && upd_ready;
        exp_drop = push && (q.size() == DEPTH) && !pop;
        chk("redirect_valid", redirect_valid_o, m_pend);
        chk("redirect_pcc", redirect_pcc_o, m_pend ? m_tgt : '0);
        chk("upd_valid", upd_valid_o, q.size() > 0);
        if (q.size() > 0) begin
            chk("upd_is_btb", upd_is_btb_o, q[0].is_btb);
            chk("upd_pc", upd_pc_o, q[0].pc);
            chk("upd_target", upd_target_o, q[0].tgt);
            chk("upd_taken", upd_taken_o, q[0].taken);
        end else begin
            chk("upd_idle", {upd_is_btb_o, upd_taken_o, upd_pc_o, upd_target_o}, '0);
        end
        chk("upd_drop", upd_drop_o, exp_drop);
`ifdef BP_RESOLVE_PERF_CNT_EN
        chk("perf_resolved", perf_resolved_o, m_perf_res);
        chk("perf_mispredict", perf_mispredict_o, m_perf_mis);
        chk("perf_drop", perf_drop_o, m_perf_drop);
`endif
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0;
            q.delete();
            m_perf_res = 0; m_perf_mis = 0; m_perf_drop = 0;
        end else begin
            if (res_valid && m_perf_res != 32'hFFFF_FFFF) m_perf_res++;
            if (res_valid && res_mis && m_perf_mis != 32'hFFFF_FFFF) m_perf_mis++;
            if (exp_drop && m_perf_drop != 32'hFFFF_FFFF) m_perf_drop++;
            if (flush) begin
                m_pend = 1'b0;
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    e.is_btb = (res_cf == 3'd3);
                    e.pc     = res_pc;
                    e.tgt    = e.is_btb ? res_target[VLEN-1:0] : '0;
                    e.taken  = e.is_btb ? 1'b0 : res_taken;
                    if (q.size() == DEPTH) void'(q.pop_front());
                    q.push_back(e);
                end
                if (m_pend && redirect_ready) m_pend = 1'b0;
                if (!m_pend && res_valid && res_mis) begin
                    m_pend = 1'b1;
                    m_tgt  = res_target;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [VLEN-1:0] pc, input logic [PCLEN-1:0] tgt,
                         input bit tk, input bit mis, input logic [2:0] cf,
                         input bit fl, input bit rr, input bit ur);
        res_valid = v; res_pc = pc; res_target = tgt; res_taken = tk; res_mis = mis;
        res_cf = cf; flush = fl; redirect_ready = rr; upd_ready = ur;
        cyc();
    endtask

    task automatic idle(input int n, input bit rr, input bit ur);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0, rr, ur);
    endtask

    initial begin
        rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_target = '0; res_taken = 1'b0;
        res_mis = 1'b0; res_cf = 3'd0; flush = 1'b0; redirect_ready = 1'b0; upd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        rst = 1'b0;
        idle(1, 1'b0, 1'b0);

        // Branch mispredict, redirect held for 3 cycles, then accepted
        drive(1'b1, 64'h1000, 128'h2000, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("tp_pcc_first", redirect_pcc_o, 128'h2000);
        idle(3, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b1);

        // Five Branch pushes into a blocked FIFO; the fifth evicts the first
        for (int i = 1; i <= 5; i++)
            drive(1'b1, 64'h4000 + 64'(i), 128'h0, i[0], 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("tp_head_after_drop", upd_pc_o, 64'h4002);
        idle(4, 1'b0, 1'b1);

        // JumpR mispredict makes a BTB entry; Return mispredict does not
        drive(1'b1, 64'h7000, 128'h8004, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        drive(1'b1, 64'h7100, 128'h9000, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b0, 1'b1);

        // Back-to-back redirects
        drive(1'b1, 64'h1000, 128'h2000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h1100, 128'h3000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("tp_older_wins", redirect_pcc_o, 128'h2000);
        drive(1'b1, 64'h1100, 128'h3000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("tp_newer_taken", redirect_pcc_o, 128'h3000);
        idle(1, 1'b1, 1'b0);

        // Flush during REDIRECT with two queued entries and a concurrent resolve
        drive(1'b1, 64'h5000, 128'h0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h5004, 128'h0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h5008, 128'h6000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h500c, 128'h6100, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        chk("tp_flush_redirect", redirect_valid_o, 1'b0);
        chk("tp_flush_fifo", upd_valid_o, 1'b0);
        idle(1, 1'b0, 1'b0);

        // Reset in the middle of a redirect
        drive(1'b1, 64'h1000, 128'h2000, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(2, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 1) == 1,
                  {$urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  3'($urandom_range(0, 4)),
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
        end
        rst = 1'b0;
        idle(2, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
